// File: rtl/sr_run_monitor_pkg.sv
// Shared types for the schoolRISCV run monitor.
package sr_run_monitor_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    XFETCH  = 2'd1,
    STALL   = 2'd2,
    TIMEOUT = 2'd3
  } fail_code_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } mon_state_t;

  // Index width for n slots; a single slot still gets one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_match_detect.sv
// Masked N-way signature comparator; the lowest matching enabled slot wins.
module sr_match_detect #(
  parameter int WIDTH    = 32,
  parameter int N_EXPECT = 2,
  parameter int IDX_W    = 1
) (
  input  logic [WIDTH-1:0]               regData,
  input  logic [N_EXPECT-1:0][WIDTH-1:0] expData,
  input  logic [N_EXPECT-1:0]            expMask,
  output logic                           hit,
  output logic [IDX_W-1:0]               idx
);

  // Scan from the top slot down so the lowest index is the one left standing.
  // An unknown debug value never counts as a hit.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    if (!$isunknown(regData)) begin
      for (int i = N_EXPECT - 1; i >= 0; i--) begin
        if (expMask[i] && (regData == expData[i])) begin
          hit = 1'b1;
          idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sr_run_monitor.sv
// Run monitor: decides PASS/FAIL of a CPU run from fetch bus and debug register.
module sr_run_monitor
  import sr_run_monitor_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int N_EXPECT    = 2,
  parameter int MATCH_HOLD  = 1,
  parameter int STALL_LIMIT = 16,
  parameter int MAX_CYCLES  = 1000,
  parameter int CNT_W       = $clog2(MAX_CYCLES + 1),
  parameter int IDX_W       = idxWidth(N_EXPECT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               imAddr,
  input  logic [WIDTH-1:0]               imData,
  input  logic [WIDTH-1:0]               regData,
  input  logic [N_EXPECT-1:0][WIDTH-1:0] expData,
  input  logic [N_EXPECT-1:0]            expMask,
  output logic                           done,
  output logic                           pass,
  output logic [1:0]                     failCode,
  output logic [IDX_W-1:0]               matchIdx,
  output logic [CNT_W-1:0]               cycleCount
);

  localparam int MR_W = $clog2(MATCH_HOLD + 1);
  localparam int SC_W = $clog2(STALL_LIMIT);

  mon_state_t       state;
  logic [MR_W-1:0]  matchRun;
  logic [IDX_W-1:0] matchSlot;
  logic [SC_W-1:0]  stallCnt;
  logic [WIDTH-1:0] prevAddr;
  logic             prevValid;

  logic             hit;
  logic [IDX_W-1:0] idx;

  sr_match_detect #(.WIDTH(WIDTH), .N_EXPECT(N_EXPECT), .IDX_W(IDX_W)) uMatch (
    .regData (regData),
    .expData (expData),
    .expMask (expMask),
    .hit     (hit),
    .idx     (idx)
  );

  logic [CNT_W-1:0] cntNext;
  logic [MR_W-1:0]  mrNext;
  logic [SC_W-1:0]  scNext;
  logic             sameAddr, xNow, passNow, stallNow, timeoutNow;

  // Next-value arithmetic and the four decision conditions for this run cycle.
  always_comb begin
    cntNext    = cycleCount + CNT_W'(1);
    mrNext     = '0;
    if (hit)
      mrNext = (matchRun != '0 && idx == matchSlot) ? matchRun + MR_W'(1) : MR_W'(1);
    sameAddr   = prevValid && (imAddr == prevAddr);
    scNext     = sameAddr ? stallCnt + SC_W'(1) : '0;
    xNow       = $isunknown(imData);
    passNow    = hit && (mrNext == MR_W'(MATCH_HOLD));
    stallNow   = sameAddr && (scNext == SC_W'(STALL_LIMIT - 1));
    timeoutNow = (cntNext == CNT_W'(MAX_CYCLES));
  end

  // FSM plus counters; PASS/FAIL freeze everything until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      matchRun   <= '0;
      matchSlot  <= '0;
      stallCnt   <= '0;
      prevAddr   <= '0;
      prevValid  <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      failCode   <= NONE;
      matchIdx   <= '0;
      cycleCount <= '0;
    end else if (state == RUN) begin
      cycleCount <= cntNext;
      matchRun   <= mrNext;
      matchSlot  <= idx;
      prevAddr   <= imAddr;
      prevValid  <= 1'b1;
      stallCnt   <= scNext;
      if (xNow) begin
        state    <= FAIL;
        done     <= 1'b1;
        failCode <= XFETCH;
      end else if (passNow) begin
        state    <= PASS;
        done     <= 1'b1;
        pass     <= 1'b1;
        matchIdx <= idx;
      end else if (stallNow) begin
        state    <= FAIL;
        done     <= 1'b1;
        failCode <= STALL;
      end else if (timeoutNow) begin
        state    <= FAIL;
        done     <= 1'b1;
        failCode <= TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_sr_run_monitor.sv
// Directed bench for sr_run_monitor: three parameterizations share one stimulus bus.
module tb_sr_run_monitor;

  localparam logic [31:0] SIG0 = 32'h00213d05;
  localparam logic [31:0] SIG1 = 32'h1c8cfc00;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      imAddr, imData, regData;
  logic [1:0][31:0] expData;
  logic [1:0]       expMask;

  logic       doneA, passA, doneB, passB, doneC, passC;
  logic [1:0] fcA, fcB, fcC;
  logic [0:0] idxA, idxB, idxC;
  logic [9:0] cntA, cntB;
  logic [2:0] cntC;

  int nCmp = 0;
  int nBad = 0;
  bit fourState;

  always #5 clk = ~clk;

  sr_run_monitor dutA (
    .clk(clk), .rst(rst), .imAddr(imAddr), .imData(imData), .regData(regData),
    .expData(expData), .expMask(expMask), .done(doneA), .pass(passA),
    .failCode(fcA), .matchIdx(idxA), .cycleCount(cntA));

  sr_run_monitor #(.MATCH_HOLD(3)) dutB (
    .clk(clk), .rst(rst), .imAddr(imAddr), .imData(imData), .regData(regData),
    .expData(expData), .expMask(expMask), .done(doneB), .pass(passB),
    .failCode(fcB), .matchIdx(idxB), .cycleCount(cntB));

  sr_run_monitor #(.MAX_CYCLES(5)) dutC (
    .clk(clk), .rst(rst), .imAddr(imAddr), .imData(imData), .regData(regData),
    .expData(expData), .expMask(expMask), .done(doneC), .pass(passC),
    .failCode(fcC), .matchIdx(idxC), .cycleCount(cntC));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       r;
    logic       xd;
    logic [31:0] rd;
    logic       eDone;
    logic       ePass;
    logic [1:0] eFc;
    logic       eIdx;
    logic [2:0] eCnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic probe;
    probe     = 1'bx;
    fourState = $isunknown(probe);

    // MAX_CYCLES=5 instance: reset, timeout, freeze, PASS on last cycle, XFETCH, 1-cycle PASS
    tbl[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1};
    tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd2};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd3};
    tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd4};
    tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'd3, 1'b0, 3'd5};
    tbl[6]  = '{1'b0, 1'b0, SIG0,  1'b1, 1'b0, 2'd3, 1'b0, 3'd5};
    tbl[7]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd2};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd3};
    tbl[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd4};
    tbl[12] = '{1'b0, 1'b0, SIG1,  1'b1, 1'b1, 2'd0, 1'b1, 3'd5};
    tbl[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2'd0, 1'b1, 3'd5};
    tbl[14] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
    tbl[15] = '{1'b0, 1'b1, SIG0,  1'b1, 1'b0, 2'd1, 1'b0, 3'd1};
    tbl[16] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
    tbl[17] = '{1'b0, 1'b0, SIG0,  1'b1, 1'b1, 2'd0, 1'b0, 3'd1};

    rst     = 1'b1;
    imAddr  = '0;
    imData  = 32'h13;
    regData = '0;
    expData = {SIG1, SIG0};
    expMask = 2'b11;
    #2;

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].xd && !fourState) continue;
      rst     = tbl[i].r;
      regData = tbl[i].rd;
      imData  = tbl[i].xd ? 32'hxxxxxxxx : 32'h13;
      imAddr  = 32'(i * 4);
      cyc();
      chk($sformatf("vec%0d.done", i), doneC, tbl[i].eDone);
      chk($sformatf("vec%0d.pass", i), passC, tbl[i].ePass);
      chk($sformatf("vec%0d.failCode", i), fcC, tbl[i].eFc);
      chk($sformatf("vec%0d.matchIdx", i), idxC, tbl[i].eIdx);
      chk($sformatf("vec%0d.cycleCount", i), cntC, tbl[i].eCnt);
    end
    imData = 32'h13;

    // Defaults: signature 0 appears on run cycle 40
    doReset();
    for (int k = 1; k <= 40; k++) begin
      imAddr  = 32'(k * 4);
      regData = (k == 40) ? SIG0 : 32'(k - 1);
      cyc();
      if (k == 39) chk("sig.notYet", doneA, 1'b0);
    end
    chk("sig.done", doneA, 1'b1);
    chk("sig.pass", passA, 1'b1);
    chk("sig.idx", idxA, 1'b0);
    chk("sig.cnt", cntA, 10'd40);
    chk("sig.fc", fcA, 2'd0);

    // Reset after a decision clears everything
    doReset();
    chk("rstDone.done", doneA, 1'b0);
    chk("rstDone.pass", passA, 1'b0);
    chk("rstDone.cnt", cntA, 10'd0);

    // MATCH_HOLD=3: two hits, a miss, then held from cycle 10
    for (int k = 1; k <= 12; k++) begin
      imAddr  = 32'(k * 4);
      regData = (k <= 2 || k >= 10) ? SIG1 : 32'h0;
      cyc();
      if (k == 11) chk("hold.notYet", doneB, 1'b0);
    end
    chk("hold.done", doneB, 1'b1);
    chk("hold.pass", passB, 1'b1);
    chk("hold.idx", idxB, 1'b1);
    chk("hold.cnt", cntB, 10'd12);

    // Same pattern with slot 1 masked off runs into the budget
    expMask = 2'b01;
    doReset();
    for (int k = 1; k <= 1000; k++) begin
      imAddr  = 32'(k * 4);
      regData = (k <= 2 || k >= 10) ? SIG1 : 32'h0;
      cyc();
      if (k == 999) chk("tmo.notYet", doneB, 1'b0);
    end
    chk("tmo.done", doneB, 1'b1);
    chk("tmo.pass", passB, 1'b0);
    chk("tmo.fc", fcB, 2'd3);
    chk("tmo.cnt", cntB, 10'd1000);
    expMask = 2'b11;

    // PC advances until cycle 20 then sticks
    regData = 32'h0;
    doReset();
    for (int k = 1; k <= 35; k++) begin
      imAddr = (k <= 20) ? 32'(k * 4) : 32'd80;
      cyc();
      if (k == 34) chk("stall.notYet", doneA, 1'b0);
    end
    chk("stall.done", doneA, 1'b1);
    chk("stall.fc", fcA, 2'd2);
    chk("stall.cnt", cntA, 10'd35);

    // X fetch outranks a simultaneous signature hit
    if (fourState) begin
      doReset();
      for (int k = 1; k <= 7; k++) begin
        imAddr  = 32'(k * 4);
        regData = (k == 7) ? SIG0 : 32'h0;
        imData  = (k == 7) ? 32'hxxxxxxxx : 32'h13;
        cyc();
      end
      imData = 32'h13;
      chk("xf.done", doneA, 1'b1);
      chk("xf.pass", passA, 1'b0);
      chk("xf.fc", fcA, 2'd1);
      chk("xf.cnt", cntA, 10'd7);
    end

    // Reset mid-run at cycle 12, count restarts at 1
    regData = 32'h0;
    doReset();
    for (int k = 1; k <= 11; k++) begin
      imAddr = 32'(k * 4);
      cyc();
    end
    chk("midrst.before", cntA, 10'd11);
    rst = 1'b1;
    cyc();
    chk("midrst.cnt", cntA, 10'd0);
    chk("midrst.done", doneA, 1'b0);
    rst    = 1'b0;
    imAddr = 32'h100;
    cyc();
    chk("midrst.restart", cntA, 10'd1);
    chk("midrst.running", doneA, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/sr_run_monitor.md
# sr_run_monitor

Parametrised self-checking run monitor for the schoolRISCV CPU. It observes the instruction fetch bus and the debug register port each clock and decides the outcome of a program run. A run passes when the debug register holds any of N programmable signatures for a configurable number of consecutive cycles. A run fails on an X fetch, a PC stall or a cycle-budget timeout. The monitor instantiates beside `sr_cpu`/`instruction_rom` in benches and drives `$finish` logic from registered status, so that status can also be probed in FPGA builds.

## Interface
- `WIDTH`, 32: data/address width of `imAddr`, `imData`, `regData`, `expData`.
- `N_EXPECT`, 2: number of signature slots, 1..16.
- `MATCH_HOLD`, 1: consecutive matching cycles (same slot) required for PASS, ≥1.
- `STALL_LIMIT`, 16: consecutive cycles with unchanged `imAddr` that trigger FAIL, ≥2.
- `MAX_CYCLES`, 1000: run-cycle budget, ≥1.
- `CNT_W`, `$clog2(MAX_CYCLES+1)`: width of `cycleCount`.
- `clk` in 1: the single clock; all state changes on posedge.
- `rst` in 1: synchronous, active-high reset.
- `imAddr` in WIDTH: CPU instruction address.
- `imData` in WIDTH: fetched instruction.
- `regData` in WIDTH: debug register value (`regAddr` is driven by the bench).
- `expData` in N_EXPECT×WIDTH: signature values. Must be held stable during a run.
- `expMask` in N_EXPECT: slot enable. Disabled slots never match.
- `done` out 1: run decided. Sticky until `rst`.
- `pass` out 1: run passed. Valid when `done`.
- `failCode` out 2: 0 NONE, 1 XFETCH, 2 STALL, 3 TIMEOUT.
- `matchIdx` out `$clog2(N_EXPECT)` (min 1): slot that produced PASS.
- `cycleCount` out CNT_W: run cycles evaluated. Freezes at decision.

## Operation
- States: RUN, PASS, FAIL. `rst`=1 forces RUN and clears all counters. Outputs reset to `done`=0, `pass`=0, `failCode`=0, `matchIdx`=0, `cycleCount`=0. `prevValid` and `matchRun`/`stallCnt` are also cleared.
- Each posedge in RUN with `rst`=0 is one run cycle:
  - `cycleCount` increments.
  - Conditions are evaluated in the priority order below. The first true condition wins.
- Conditions, highest priority first:
  1. XFETCH: `imData` contains any X/Z (`$isunknown`; the check is constant false under synthesis).
  2. PASS: `matchRun` reaches MATCH_HOLD in this cycle.
  3. STALL: `stallCnt` reaches STALL_LIMIT-1 and `imAddr` equals the previous sample. This means STALL_LIMIT consecutive identical samples.
  4. TIMEOUT: this is run cycle number MAX_CYCLES.
- Match:
  - `hit` is true when some slot i has `expMask[i]`=1 and `regData == expData[i]`. The lowest such i wins.
  - A `regData` value containing X/Z is no hit.
  - `matchRun`: reset to 1 on a hit to a new slot, increment on a hit to the same slot, clear on a miss.
- Stall:
  - The first run cycle after reset only loads the previous `imAddr` and sets `prevValid`.
  - After that, `stallCnt` increments when `imAddr` equals the previous sample and clears otherwise.
- PASS and FAIL are terminal. All inputs are ignored and all outputs are frozen until `rst`.
- `rst` asserted mid-run or after a decision aborts or clears everything on that edge. The next run starts on the first edge with `rst`=0.

## Timing
- All outputs are registered. A condition sampled at edge k is visible on outputs immediately after edge k. There are no combinational input-to-output paths.
- Shortest PASS: MATCH_HOLD cycles after reset release, with `cycleCount`=MATCH_HOLD.
- TIMEOUT: `done` rises on the edge where `cycleCount` becomes MAX_CYCLES.
- Simultaneous events follow the priority order above. Example: a signature hit on the final budget cycle yields PASS, not TIMEOUT.

## Structure
- Package `sr_run_monitor_pkg`:
  - `fail_code_t` enum (NONE/XFETCH/STALL/TIMEOUT).
  - `mon_state_t` enum (RUN/PASS/FAIL).
- Sub-module `sr_match_detect`: combinational N_EXPECT-way masked comparator with lowest-index priority encoder. Outputs `hit`, `idx`.
- Top level holds the FSM, `cycleCount`, `matchRun`, `stallCnt`, previous-address register and the status registers.

## Test plan
- Defaults; `regData` steps 0,1,…, reaching `32'h00213d05` at run cycle 40. `expData`={`00213d05`,`1c8cfc00`}, mask 2'b11 -> `done`=1, `pass`=1, `matchIdx`=0, `cycleCount`=40.
- MATCH_HOLD=3; `regData`=`1c8cfc00` for 2 cycles, then 0, then held from cycle 10 -> PASS at cycle 12, `matchIdx`=1. Slot 1 masked off instead -> no PASS, TIMEOUT at 1000, `failCode`=3.
- `imAddr` increments by 4 until cycle 20, then holds -> FAIL STALL (`failCode`=2) at cycle 35.
- `imData`=X at run cycle 7 while `regData` matches the same cycle -> FAIL XFETCH (`failCode`=1), `cycleCount`=7.
- MAX_CYCLES=5, no hits -> TIMEOUT at `cycleCount`=5. A hit on cycle 5 -> PASS instead.
- `rst` pulsed at run cycle 12 and again after a decision -> all outputs 0 next edge. Counting restarts from 1 on the first cycle with `rst`=0.
